// File: rtl/ili_spi_slave.sv
// ili_spi_slave
//   SPI mode-0 slave with an ILI9341-style command/data byte decoder. Serves
//   as the display-side loopback target for the ILI9341 SPI master path.
//   Every received byte is tagged with its dc bit and a parameter ordinal.
//   The tagged byte is queued in a small show-ahead FIFO that the consumer
//   drains with a valid/ready handshake.
//
// Ports
//   clk, rst              system clock, asynchronous active-low reset
//   sclk, mosi, cs, dc    SPI stream from the master (asynchronous to clk)
//   miso                  registered serial data back to the master
//   i_tx_data, o_tx_req   next byte to return; pulse when it has been loaded
//   o_data, o_dc,
//   o_param_idx, o_valid,
//   i_ready               FIFO head entry and pop handshake
//   o_overflow, i_clr_ovf sticky drop flag and its clear
//   o_frame_err           pulse: cs deasserted in the middle of a byte
//   o_busy                chip select (synchronized) asserted
module ili_spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             cs,
    input  logic             dc,
    output logic             miso,
    input  logic [7:0]       i_tx_data,
    output logic             o_tx_req,
    output logic [7:0]       o_data,
    output logic             o_dc,
    output logic [IDX_W-1:0] o_param_idx,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overflow,
    input  logic             i_clr_ovf,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 9 + IDX_W;
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Parameter ordinal advance, holding at the top value instead of wrapping.
    function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
        return (&v) ? v : v + IDX_ONE;
    endfunction

    // ---------------- input synchronizers and edge detection ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q,   dc_sync_d;
    logic sclk_s, mosi_s, cs_s, dc_s;
    logic sclk_dly_q, sclk_dly_d, cs_dly_q, cs_dly_d;
    logic mosi_dly_q, mosi_dly_d, dc_dly_q, dc_dly_d;
    logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];

    // Edge pulses are registered; mosi/dc get the same one-cycle delay so the
    // data bit seen with a rise pulse is the one sampled when sclk went high.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs};
        dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0],   dc};
        sclk_dly_d  = sclk_s;
        cs_dly_d    = cs_s;
        mosi_dly_d  = mosi_s;
        dc_dly_d    = dc_s;
        sclk_rise_d = sclk_s & ~sclk_dly_q;
        sclk_fall_d = ~sclk_s & sclk_dly_q;
        cs_fall_d   = ~cs_s & cs_dly_q;
        cs_rise_d   = cs_s & ~cs_dly_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            dc_sync_q   <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            mosi_dly_q  <= 1'b0;
            dc_dly_q    <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            dc_sync_q   <= dc_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_dly_q    <= cs_dly_d;
            mosi_dly_q  <= mosi_dly_d;
            dc_dly_q    <= dc_dly_d;
            sclk_rise_q <= sclk_rise_d;
            sclk_fall_q <= sclk_fall_d;
            cs_fall_q   <= cs_fall_d;
            cs_rise_q   <= cs_rise_d;
        end
    end

    // ---------------- shift FSM and byte tagging ----------------
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       tx_q, tx_d;
    logic             miso_q, miso_d;
    logic             tx_req_q, tx_req_d;
    logic             frame_err_q, frame_err_d;
    logic             byte_vld_q, byte_vld_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             byte_dc_q, byte_dc_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0] param_cnt_q, param_cnt_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        tx_req_d    = 1'b0;
        frame_err_d = 1'b0;
        byte_vld_d  = 1'b0;
        byte_data_d = byte_data_q;
        byte_dc_d   = byte_dc_q;
        byte_idx_d  = byte_idx_q;
        param_cnt_d = param_cnt_q;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 3'd0;
                    tx_d      = i_tx_data;
                    tx_req_d  = 1'b1;
                end
            end
            SHIFT: begin
                // cs release takes priority over a coincident sclk rise.
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                end else if (sclk_rise_q) begin
                    rx_d = {rx_q[6:0], mosi_dly_q};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d   = 3'd0;
                        byte_vld_d  = 1'b1;
                        byte_data_d = {rx_q[6:0], mosi_dly_q};
                        byte_dc_d   = dc_dly_q;
                        byte_idx_d  = dc_dly_q ? param_cnt_q : '0;
                        param_cnt_d = dc_dly_q ? sat_inc(param_cnt_q) : '0;
                        tx_d        = i_tx_data;
                        tx_req_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (sclk_fall_q && bit_cnt_q != 3'd0) begin
                    // No shift on the fall right after a (re)load: the new MSB
                    // must still be on miso at the next rise.
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
        miso_d = (state_d == SHIFT) ? tx_d[7] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            tx_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
            byte_vld_q  <= 1'b0;
            byte_data_q <= '0;
            byte_dc_q   <= 1'b0;
            byte_idx_q  <= '0;
            param_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            tx_req_q    <= tx_req_d;
            frame_err_q <= frame_err_d;
            byte_vld_q  <= byte_vld_d;
            byte_data_q <= byte_data_d;
            byte_dc_q   <= byte_dc_d;
            byte_idx_q  <= byte_idx_d;
            param_cnt_q <= param_cnt_d;
        end
    end

    // ---------------- receive FIFO ----------------
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             pop, full, wr_en;
    logic [ENT_W-1:0] head;

    always_comb begin
        pop   = (count_q != '0) & i_ready;
        full  = (count_q == DEPTH_C);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en = byte_vld_q & (~full | pop);
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {byte_dc_q, byte_idx_q, byte_data_q};
        end
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_ONE;
        end
        ovf_d = ovf_q;
        if (byte_vld_q && full && !pop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign o_data      = head[7:0];
    assign o_param_idx = head[8 +: IDX_W];
    assign o_dc        = head[ENT_W-1];
    assign o_valid     = (count_q != '0);
    assign o_overflow  = ovf_q;
    assign o_frame_err = frame_err_q;
    assign o_tx_req    = tx_req_q;
    assign miso        = miso_q;
    assign o_busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_ili_spi_slave.sv
// Self-checking bench for ili_spi_slave. The bench acts as the SPI master
// (sclk = clk/16) and as the FIFO consumer. A queue-based model tracks the
// expected FIFO entries, parameter ordinals, the overflow flag, and the miso
// bytes.
module tb_ili_spi_slave;

    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int IDXW  = 4;
    localparam int H     = 8;   // clk cycles per sclk half period

    logic        clk, rst, sclk, mosi, cs, dc, i_ready, i_clr_ovf;
    logic [7:0]  i_tx_data;
    logic        miso, o_tx_req, o_dc, o_valid, o_overflow, o_frame_err, o_busy;
    logic [7:0]  o_data;
    logic [IDXW-1:0] o_param_idx;

    ili_spi_slave #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .IDX_W(IDXW)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .dc(dc),
        .miso(miso), .i_tx_data(i_tx_data), .o_tx_req(o_tx_req),
        .o_data(o_data), .o_dc(o_dc), .o_param_idx(o_param_idx),
        .o_valid(o_valid), .i_ready(i_ready), .o_overflow(o_overflow),
        .i_clr_ovf(i_clr_ovf), .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [12:0] mq[$];      // {dc, idx, data}
    int          pcnt = 0;
    logic        ovf_exp = 1'b0;
    logic [7:0]  tx_exp = 8'h00;
    int          txreq_exp = 0, txreq_cnt = 0;
    int          ferr_exp = 0, ferr_cnt = 0;
    int          pop_cnt = 0;
    bit          rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer side: every pop is compared against the model queue head.
    always @(negedge clk) begin
        if (o_tx_req) txreq_cnt++;
        if (o_frame_err) ferr_cnt++;
        if (o_valid && i_ready) begin
            if (mq.size() == 0) begin
                check("pop_on_empty_model", 32'(o_valid), 32'(1'b0));
            end else begin
                check("head", 32'({o_dc, o_param_idx, o_data}), 32'(mq.pop_front()));
                pop_cnt++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    function automatic void model_push(input logic [7:0] d, input logic dcb);
        int idx;
        idx = dcb ? pcnt : 0;
        if (mq.size() < DEPTH) mq.push_back({dcb, 4'(idx), d});
        else ovf_exp = 1'b1;
        if (!dcb) pcnt = 0;
        else if (pcnt < (1 << IDXW) - 1) pcnt = pcnt + 1;
    endfunction

    task automatic frame_begin(input logic [7:0] tx0);
        i_tx_data = tx0;
        tx_exp    = tx0;
        cs        = 1'b0;
        txreq_exp++;
        tick(H);
        check("busy_on", 32'(o_busy), 32'(1'b1));
        check("tx_req_csfall", 32'(txreq_cnt), 32'(txreq_exp));
    endtask

    task automatic frame_end();
        tick(H);
        cs = 1'b1;
        tick(H);
        check("busy_off", 32'(o_busy), 32'(1'b0));
        check("frame_err", 32'(ferr_cnt), 32'(ferr_exp));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic dcb, input logic [7:0] tx_next,
                             input int nbits, input bit lat_chk);
        logic [7:0] rxm;
        rxm = '0;
        dc  = dcb;
        for (int i = 0; i < nbits; i++) begin
            mosi = d[3'(7 - i)];
            tick(H);
            rxm  = {rxm[6:0], miso};
            sclk = 1'b1;
            if (i == 0) i_tx_data = tx_next;
            if (i == 7) begin
                model_push(d, dcb);
                txreq_exp++;
                if (lat_chk) begin
                    // First edge to sample sclk high, then SYNC+2 more edges.
                    repeat (SYNC + 2) @(posedge clk);
                    @(negedge clk);
                    check("lat_early", 32'(o_valid), 32'(1'b0));
                    @(posedge clk);
                    @(negedge clk);
                    check("lat_valid", 32'(o_valid), 32'(1'b1));
                    @(posedge clk);
                    #1;
                    tick(H - SYNC - 4);
                end else begin
                    tick(H);
                end
                check("miso_byte", 32'(rxm), 32'(tx_exp));
                tx_exp = tx_next;
                check("tx_req", 32'(txreq_cnt), 32'(txreq_exp));
                check("overflow", 32'(o_overflow), 32'(ovf_exp));
            end else begin
                tick(H);
            end
            sclk = 1'b0;
        end
    endtask

    initial begin
        int p0;
        logic [7:0] t;
        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0;
        i_tx_data = 8'h00; i_ready = 1'b0; i_clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'(1'b0));
        check("rst_miso", 32'(miso), 32'(1'b0));
        check("rst_ovf", 32'(o_overflow), 32'(1'b0));
        check("rst_busy", 32'(o_busy), 32'(1'b0));
        check("rst_txreq", 32'(o_tx_req), 32'(1'b0));
        check("rst_ferr", 32'(o_frame_err), 32'(1'b0));
        check("rst_head", 32'({o_dc, o_param_idx, o_data}), 32'(0));
        rst = 1'b1;
        tick(2);

        // Single command byte with latency measurement
        frame_begin(8'h96);
        send_byte(8'h2A, 1'b0, 8'h00, 8, 1'b1);
        frame_end();
        check("t1_head", 32'({o_dc, o_param_idx, o_data}), 32'({1'b0, 4'd0, 8'h2A}));
        i_ready = 1'b1;
        tick(3);
        check("t1_empty", 32'(o_valid), 32'(1'b0));

        // Command followed by three parameters, consumer always ready
        p0 = pop_cnt;
        frame_begin(8'h00);
        send_byte(8'h2C, 1'b0, 8'h00, 8, 1'b0);
        send_byte(8'h11, 1'b1, 8'h00, 8, 1'b0);
        send_byte(8'h22, 1'b1, 8'h00, 8, 1'b0);
        send_byte(8'h33, 1'b1, 8'h00, 8, 1'b0);
        frame_end();
        check("t2_pops", 32'(pop_cnt - p0), 32'(4));
        check("t2_empty", 32'(o_valid), 32'(1'b0));

        // miso returns 0xA5 then 0x3C
        frame_begin(8'hA5);
        send_byte(8'h5A, 1'b1, 8'h3C, 8, 1'b0);
        send_byte(8'hC3, 1'b1, 8'h00, 8, 1'b0);
        frame_end();

        // Overflow with a stalled consumer, drain, clear
        i_ready = 1'b0;
        frame_begin(8'h00);
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 8'h00, 8, 1'b0);
        frame_end();
        check("t4_ovf", 32'(o_overflow), 32'(1'b1));
        p0 = pop_cnt;
        i_ready = 1'b1;
        tick(8);
        check("t4_pops", 32'(pop_cnt - p0), 32'(4));
        check("t4_empty", 32'(o_valid), 32'(1'b0));
        i_clr_ovf = 1'b1;
        tick(1);
        i_clr_ovf = 1'b0;
        ovf_exp = 1'b0;
        tick(1);
        check("t4_clr", 32'(o_overflow), 32'(1'b0));

        // Truncated byte, then a clean one
        i_ready = 1'b0;
        frame_begin(8'h00);
        send_byte(8'hFF, 1'b1, 8'h00, 5, 1'b0);
        ferr_exp++;
        frame_end();
        check("t5_no_entry", 32'(o_valid), 32'(1'b0));
        i_ready = 1'b1;
        frame_begin(8'h00);
        send_byte(8'h81, 1'b0, 8'h00, 8, 1'b0);
        frame_end();
        check("t5_empty", 32'(o_valid), 32'(1'b0));

        // Randomized frames with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            t = 8'($urandom);
            frame_begin(t);
            for (int b = 0, nb = $urandom_range(1, 4); b < nb; b++) begin
                t = 8'($urandom);
                send_byte(8'($urandom), 1'($urandom_range(0, 1)), t, 8, 1'b0);
            end
            frame_end();
        end
        // Long parameter run reaches the saturating ordinal
        frame_begin(8'($urandom));
        send_byte(8'h2B, 1'b0, 8'($urandom), 8, 1'b0);
        for (int b = 0; b < 18; b++) send_byte(8'($urandom), 1'b1, 8'($urandom), 8, 1'b0);
        frame_end();
        rand_ready = 1'b0;
        i_ready = 1'b1;
        tick(10);
        check("rand_empty", 32'(o_valid), 32'(1'b0));

        // Reset in the middle of a byte with entries queued and overflow set
        i_ready = 1'b0;
        frame_begin(8'hFF);
        for (int b = 0; b < 5; b++) send_byte(8'(8'h10 + b), 1'b1, 8'hFF, 8, 1'b0);
        frame_end();
        i_ready = 1'b1;
        tick(2);
        i_ready = 1'b0;
        tick(1);
        check("t6_ovf_pre", 32'(o_overflow), 32'(1'b1));
        check("t6_valid_pre", 32'(o_valid), 32'(1'b1));
        frame_begin(8'hFF);
        send_byte(8'h00, 1'b1, 8'hFF, 3, 1'b0);
        check("t6_miso_pre", 32'(miso), 32'(1'b1));
        rst = 1'b0;
        #1;
        check("t6_valid", 32'(o_valid), 32'(1'b0));
        check("t6_miso", 32'(miso), 32'(1'b0));
        check("t6_ovf", 32'(o_overflow), 32'(1'b0));
        check("t6_busy", 32'(o_busy), 32'(1'b0));
        cs = 1'b1; sclk = 1'b0;
        mq.delete();
        pcnt = 0;
        ovf_exp = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        i_ready = 1'b1;
        p0 = pop_cnt;
        frame_begin(8'h5A);
        send_byte(8'h77, 1'b1, 8'h00, 8, 1'b0);
        frame_end();
        check("t6_pops", 32'(pop_cnt - p0), 32'(1));
        check("t6_empty", 32'(o_valid), 32'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ili_spi_slave.md
Name: ili_spi_slave

Overview:
- SPI mode-0 slave and ILI9341-style command/data byte decoder.
- It is the display-side counterpart of the ILI9341 SPI master path. It receives the sclk/mosi/cs/dc stream and returns miso bytes.
- Used as a synthesizable loopback target and display model for bring-up on the same board.
- Received bytes are tagged with the dc bit and a parameter index, then buffered in a small FIFO with a valid/ready handshake toward the consumer.

Parameters:
- SYNC_STAGES, 2: flops in each input synchronizer (sclk, mosi, cs, dc); minimum 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of two.
- IDX_W, 4: width of the parameter index counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from the master (asynchronous to clk).
- mosi  in  1  serial data from the master.
- cs  in  1  chip select, active-low.
- dc  in  1  0 = command byte, 1 = data/parameter byte.
- miso  out  1  serial data to the master.
- i_tx_data  in  8  next byte to return on miso.
- o_tx_req  out  1  1-cycle pulse when i_tx_data is loaded.
- o_data  out  8  FIFO head byte.
- o_dc  out  1  dc tag of the head byte.
- o_param_idx  out  IDX_W  0 for commands; parameter ordinal for data bytes.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts the head entry.
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- i_clr_ovf  in  1  clears o_overflow.
- o_frame_err  out  1  1-cycle pulse: cs deasserted mid-byte.
- o_busy  out  1  cs (synchronized) asserted.

Behaviour:
- Reset values (rst low):
  - All outputs 0; FIFO empty; bit_cnt = 0; tx shifter = 0; parameter counter = 0.
  - Synchronizers preset to idle levels: sclk 0, cs 1.
- Synchronization and edge detection:
  - Each input passes through a SYNC_STAGES flop chain.
  - Edges are detected by comparing the synchronized value with a one-cycle-delayed copy.
  - Legal sclk frequency is at most clk/4; faster sclk is unsupported.
- FSM states:
  - IDLE (cs_s = 1): ignore sclk; o_busy = 0.
  - SHIFT (cs_s = 0).
- IDLE -> SHIFT on cs falling edge:
  - bit_cnt <= 0.
  - tx shifter <= i_tx_data; o_tx_req pulses.
- SHIFT, on sclk rise:
  - rx shifter <= {rx[6:0], mosi_s} (MSB first); bit_cnt increments.
  - On the 8th rise: form the byte; sample dc_s; bit_cnt <= 0; tx shifter reloads from i_tx_data; o_tx_req pulses.
- SHIFT, on sclk fall with bit_cnt != 0: tx shifter shifts left.
  - A fall with bit_cnt = 0 does not shift, so the freshly loaded MSB is held for the first rise.
- miso:
  - Equals tx shifter[7] while cs_s = 0, otherwise 0.
  - Registered output; no tristate.
- Parameter index:
  - dc = 0 byte: pushed with idx 0; the counter then resets to 0.
  - dc = 1 byte: pushed with the current counter value; the counter then increments, saturating at 2^IDX_W - 1.
  - Data bytes before any command start at idx 0.
- FIFO push:
  - A completed byte is pushed one clk after the detected 8th rise.
  - o_valid rises exactly SYNC_STAGES+2 clk edges after the first clk edge that samples sclk high for that rise.
- FIFO pop:
  - Occurs when o_valid & i_ready.
  - The FIFO is show-ahead: o_data, o_dc and o_param_idx are valid whenever o_valid = 1.
- FIFO boundary cases:
  - Push when full without a pop in the same cycle: byte dropped, o_overflow <= 1, parameter counter still advances.
  - Push and pop in the same cycle while full: both accepted, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- o_overflow:
  - Cleared by i_clr_ovf.
  - If a set event and i_clr_ovf occur in the same cycle, set wins.
- cs rising edge (SHIFT -> IDLE):
  - If bit_cnt != 0: discard the partial byte, pulse o_frame_err, bit_cnt <= 0.
  - The parameter counter is preserved across cs toggles.
- Simultaneous sclk rise and cs rise: cs wins; the rise is ignored.
- Asynchronous reset mid-byte: all state is cleared immediately, including FIFO contents and the sticky overflow flag.

Test Plan:
1. cs low, dc = 0, shift 0x2A MSB-first, cs high -> one entry {o_data = 0x2A, o_dc = 0, idx = 0}; o_valid at SYNC_STAGES+2 edges after the 8th rise; no o_frame_err.
2. Command 0x2C followed by data 0x11, 0x22, 0x33 (dc = 1), i_ready held high -> four pops with idx 0, 0, 1, 2 and o_dc 0, 1, 1, 1.
3. i_tx_data = 0xA5 at cs fall, then 0x3C -> miso bits sampled on sclk rises read 0xA5 then 0x3C; o_tx_req pulses at cs fall and after the 8th rise.
4. i_ready = 0, send 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04 and o_overflow = 1. Then i_ready = 1: pops 0x01..0x04 and o_valid drops. Pulse i_clr_ovf: o_overflow = 0.
5. cs deasserted after 5 bits -> o_frame_err pulses once, no FIFO entry. The next full byte 0x81 is received correctly.
6. Assert rst mid-byte with 2 entries queued -> o_valid = 0, miso = 0, o_overflow = 0 immediately. A subsequent byte is received normally with idx 0.
